// File: rtl/program_fetch.sv
// -----------------------------------------------------------------------------
// program_fetch
//
// Instruction-fetch stage of the bit-serial processor. It holds a small
// program store, the program counter and the instruction register. It gives
// the decoder the current 3-bit opcode and a synchronised start level.
//
// There are two modes:
//   PROG : The store can be written. The decoder sees a NOP (3'b000) and
//          o_start = 0, so it parks.
//   RUN  : The PC advances on each i_pcincr request from the decoder. The
//          next opcode is registered on the same edge, so there is no bubble.
//
// Ports
//   i_clk        system clock, all state on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_prog_en    level: 1 = PROG, 0 = RUN
//   i_prog_we    store write strobe (honoured in PROG only)
//   i_prog_addr  store write address
//   i_prog_data  opcode to write
//   i_start      raw asynchronous start button
//   i_pcincr     PC-increment request from the decoder
//   o_instr      current opcode (registered)
//   o_start      synchronised start, gated by RUN
//   o_pc         current program counter
//   o_run        1 while in RUN
// -----------------------------------------------------------------------------
module program_fetch #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_prog_en,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [2:0]        i_prog_data,
  input  logic              i_start,
  input  logic              i_pcincr,
  output logic [2:0]        o_instr,
  output logic              o_start,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_run
);

  typedef enum logic {
    S_PROG = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        NOP       = 3'b000;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        instr_q, instr_d;
  logic [2:0]        mem_q [DEPTH];
  logic [1:0]        sync_q;

  logic              addr_ok;
  logic              wr_en;
  logic              load;
  logic [2:0]        rd_data;

  // When DEPTH is a power of two, every address fits in the store, so no
  // range check is needed.
  if (DEPTH == (1 << ADDR_W)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = ({1'b0, i_prog_addr} < (ADDR_W + 1)'(DEPTH));
  end

  assign wr_en = (state_q == S_PROG) && i_prog_we && addr_ok;

  // ---------------------------------------------------------------------------
  // Next-state, next-PC and instruction-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;

    unique case (state_q)
      S_PROG: begin
        if (!i_prog_en) begin
          state_d = S_RUN;
          pc_d    = '0;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        // A mode change wins over a same-cycle increment, which is dropped.
        if (i_prog_en) begin
          state_d = S_PROG;
        end else if (i_pcincr) begin
          pc_d = (pc_q == LAST_ADDR) ? '0 : pc_q + ADDR_W'(1);
          load = 1'b1;
        end
      end
      default: begin
        state_d = S_PROG;
      end
    endcase
  end

  // The store write and the fetch of mem[0] can land on the same edge, when
  // PROG->RUN happens while address 0 is being written. In that case the
  // incoming data is forwarded so the first opcode is the new one.
  always_comb begin
    rd_data = mem_q[pc_d];
    if (wr_en && (i_prog_addr == pc_d)) begin
      rd_data = i_prog_data;
    end
  end

  always_comb begin
    instr_d = instr_q;
    if (load) begin
      instr_d = rd_data;
    end else if (state_d == S_PROG) begin
      instr_d = NOP;
    end
  end

  // ---------------------------------------------------------------------------
  // State, PC and instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge, independent of statement order.
    if (!i_rst_n) begin
      state_q <= S_PROG;
      pc_q    <= '0;
      instr_q <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Program store
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: the store is a flop array that is cleared on reset. This is
    // deliberate, because a freshly reset machine must run a program of NOPs.
    // It also means the store cannot map onto a RAM macro.
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP;
      end
    end else if (wr_en) begin
      mem_q[i_prog_addr] <= i_prog_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Start synchroniser: two flops, always clocked, level only
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_start};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_instr = instr_q;
  assign o_pc    = pc_q;
  assign o_run   = (state_q == S_RUN);
  assign o_start = sync_q[1] & o_run;

endmodule

// File: doc/program_fetch.md
# program_fetch

Instruction-fetch stage of the bit-serial processor, directly upstream of the instruction decoder. Holds the small program store, program counter and instruction register, and presents the current 3-bit opcode and a synchronised start strobe to the decoder. It advances on the decoder's PC-increment request. A program-load mode lets the board switches or a host write the store while the decoder is parked on a NOP.

## Interface
- DEPTH, 16: program store entries; ADDR_W = $clog2(DEPTH), minimum 1
- i_clk  input  1  system clock, all state on rising edge
- i_rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- i_prog_en  input  1  level; 1 = PROG mode (load), 0 = RUN mode
- i_prog_we  input  1  store write strobe, honoured only in PROG
- i_prog_addr  input  ADDR_W  store write address
- i_prog_data  input  3  opcode to write
- i_start  input  1  raw asynchronous start button
- i_pcincr  input  1  PC-increment request from decoder, one cycle per instruction
- o_instr  output  3  current opcode to decoder (registered)
- o_start  output  1  synchronised start to decoder
- o_pc  output  ADDR_W  current program counter
- o_run  output  1  1 while in RUN

## Operation
- States: PROG, RUN. Reset enters PROG.
- PROG:
  - o_instr forced to 3'b000, o_start forced 0, so the decoder idles with no PC increments.
  - i_pcincr ignored; pc held.
  - i_prog_we=1 and i_prog_addr<DEPTH: mem[i_prog_addr] <= i_prog_data. Addresses >= DEPTH are ignored, with no wrap.
- PROG->RUN on the first edge with i_prog_en=0:
  - pc <= 0.
  - o_instr <= mem[0], bypassing a same-edge write to address 0, which supplies i_prog_data.
- RUN:
  - i_pcincr=1: pc_next = (pc==DEPTH-1) ? 0 : pc+1; pc <= pc_next; o_instr <= mem[pc_next].
  - i_pcincr=0: pc and o_instr hold.
  - Writes are ignored.
- RUN->PROG on the first edge with i_prog_en=1:
  - o_instr <= 3'b000, o_start drops to 0 that edge, pc holds its value, store contents are kept.
  - i_prog_en has priority over a same-cycle i_pcincr, which is dropped.
- Start synchroniser:
  - Two flops, always clocked, reset to 0. o_start = second flop AND o_run.
  - No debounce or edge detection; the decoder uses the level (waits for high on 3'b000, waits for low on 3'b110).
- Store: flop array, asynchronously cleared to 3'b000 on reset. Read is combinational on pc_next and registered into o_instr.
- Reset mid-operation, at any time: immediate return to PROG and all reset values, regardless of the bit position of the current instruction.

## Timing
- Reset values: o_instr=3'b000, o_start=0, o_pc=0, o_run=0, store all 3'b000, sync flops 0.
- i_pcincr sampled at edge N: o_pc and o_instr show the next instruction after edge N. The decoder clears its bit count on the same edge, so the next instruction's bit 0 cycle sees the new opcode. Zero bubble.
- Back-to-back i_pcincr on consecutive cycles, e.g. chained 3'b001 NOPs: one instruction per cycle.
- Mode change: o_run and o_instr update on the edge that samples the new i_prog_en level, i.e. one cycle of latency.
- i_start to o_start: 2-cycle latency in RUN. Rising i_prog_en clears o_start combinationally via o_run on the same edge.
- Only o_start has a combinational path from internal state (o_run AND flop). No input-to-output combinational paths.

## Test plan
- Reset, hold i_prog_en=1 -> o_instr=000, o_pc=0, o_run=0, o_start=0; pulsing i_pcincr leaves o_pc=0.
- PROG: write mem[0..3]=111,100,010,001, drop i_prog_en -> next cycle o_run=1, o_pc=0, o_instr=111. Pulse i_pcincr three times -> o_instr goes 100, 010, 001, with o_pc 1, 2, 3.
- DEPTH=16, pc=15, i_pcincr -> o_pc=0 and o_instr=mem[0]. A write with i_prog_addr=15 during RUN leaves mem[15] unchanged.
- Same edge: i_prog_en falls while writing addr 0 with 011 -> o_instr=011 next cycle.
- Assert i_start in RUN -> o_start=1 exactly 2 cycles later. Raise i_prog_en with i_pcincr=1 on the same edge -> o_start=0, o_instr=000, o_pc unchanged.
- In RUN at pc=5, pulse i_rst_n low mid-cycle -> outputs reset immediately without waiting for a clock edge; store reads back all 000 after reset.
